// File: rtl/coin_tally.sv
// Coin pickup tally: counts each coin's Collision_Enable fall once per level
// in BCD, pulses Life_Up on the 99->00 wrap and drives a rising pop sprite.
// Optional score accumulator enabled by defining COIN_TALLY_SCORE_EN.
module coin_tally #(
    parameter int          NUM_COINS  = 8,
    parameter logic [19:0] STEP_DIV   = 20'd500000,
    parameter logic [15:0] POPUP_RISE = 16'd24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_COINS-1:0]   Coin_Enable,
    input  logic [32*NUM_COINS-1:0] Coin_Coordinate,
    input  logic                   Level_Clear,
    output logic [7:0]             Coin_Count,
    output logic                   Life_Up,
    output logic                   Popup_Active,
    output logic [31:0]            Popup_Coordinate,
    output logic [23:0]            Score
);

    localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RISE = 1'b1
    } pop_state_t;

    logic [NUM_COINS-1:0] prev_en;
    logic [NUM_COINS-1:0] collected;
    logic [NUM_COINS-1:0] pending;
    logic [NUM_COINS-1:0] fall;
    logic [NUM_COINS-1:0] serviced;
    logic [31:0]          cap [NUM_COINS];

    logic                 svc_valid;
    logic [IDX_W-1:0]     svc_idx;
    logic                 do_service;
    logic                 count_is_99;
    logic [7:0]           count_nxt;

    pop_state_t           state, state_nxt;
    logic [31:0]          base, base_nxt;
    logic [15:0]          offset, offset_nxt;
    logic [19:0]          divider, divider_nxt;
    logic [31:0]          coord_nxt;

    // A 0->1 rise is never an event; only a fall of a not-yet-collected coin.
    always_comb begin
        fall = prev_en & ~Coin_Enable & ~collected;
    end

    // Lowest pending index wins: iterate downward so the last hit is the lowest.
    always_comb begin
        svc_valid = 1'b0;
        svc_idx   = '0;
        serviced  = '0;
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                svc_valid   = 1'b1;
                svc_idx     = IDX_W'(i);
                serviced    = '0;
                serviced[i] = 1'b1;
            end
        end
    end

    assign do_service  = svc_valid & ~Level_Clear;
    assign count_is_99 = (Coin_Count == 8'h99);

    always_comb begin
        count_nxt = Coin_Count;
        if (Coin_Count[3:0] == 4'd9) begin
            count_nxt[3:0] = 4'd0;
            count_nxt[7:4] = (Coin_Count[7:4] == 4'd9) ? 4'd0 : Coin_Count[7:4] + 4'd1;
        end else begin
            count_nxt[3:0] = Coin_Count[3:0] + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_en    <= '0;
            collected  <= '0;
            pending    <= '0;
            Coin_Count <= 8'h00;
            Life_Up    <= 1'b0;
            for (int i = 0; i < NUM_COINS; i++) begin
                cap[i] <= 32'd0;
            end
        end else begin
            prev_en <= Coin_Enable;
            if (Level_Clear) begin
                collected <= '0;
                pending   <= '0;
                Life_Up   <= 1'b0;
            end else begin
                // A fall landing on the bit being serviced is dropped so it cannot re-count.
                pending   <= (pending & ~serviced) | (fall & ~serviced);
                collected <= collected | serviced;
                Life_Up   <= do_service & count_is_99;
                if (do_service) begin
                    Coin_Count <= count_nxt;
                end
                for (int i = 0; i < NUM_COINS; i++) begin
                    if (fall[i]) begin
                        cap[i] <= Coin_Coordinate[32*i +: 32];
                    end
                end
            end
        end
    end

    // Pop sprite: holds each offset 0..POPUP_RISE for STEP_DIV cycles, then idles.
    always_comb begin
        state_nxt   = state;
        base_nxt    = base;
        offset_nxt  = offset;
        divider_nxt = divider;
        if (Level_Clear) begin
            state_nxt   = IDLE;
            base_nxt    = 32'd0;
            offset_nxt  = 16'd0;
            divider_nxt = 20'd0;
        end else if (do_service) begin
            state_nxt   = RISE;
            base_nxt    = cap[svc_idx];
            offset_nxt  = 16'd0;
            divider_nxt = 20'd0;
        end else if (state == RISE) begin
            if (divider == STEP_DIV - 20'd1) begin
                divider_nxt = 20'd0;
                if (offset == POPUP_RISE) begin
                    state_nxt  = IDLE;
                    offset_nxt = 16'd0;
                end else begin
                    offset_nxt = offset + 16'd1;
                end
            end else begin
                divider_nxt = divider + 20'd1;
            end
        end
        coord_nxt = (state_nxt == RISE) ? {base_nxt[31:16], base_nxt[15:0] - offset_nxt} : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            base             <= 32'd0;
            offset           <= 16'd0;
            divider          <= 20'd0;
            Popup_Active     <= 1'b0;
            Popup_Coordinate <= 32'd0;
        end else begin
            state            <= state_nxt;
            base             <= base_nxt;
            offset           <= offset_nxt;
            divider          <= divider_nxt;
            Popup_Active     <= (state_nxt == RISE);
            Popup_Coordinate <= coord_nxt;
        end
    end

`ifdef COIN_TALLY_SCORE_EN
    logic [23:0] score_q;
    logic [24:0] score_sum;

    always_comb begin
        score_sum = {1'b0, score_q} + 25'd200 + (count_is_99 ? 25'd1000 : 25'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= 24'd0;
        end else if (do_service) begin
            score_q <= score_sum[24] ? 24'hFFFFFF : score_sum[23:0];
        end
    end

    assign Score = score_q;
`else
    assign Score = 24'd0;
`endif

endmodule

// File: doc/coin_tally.md
Name: coin_tally

Overview:
- Downstream of the per-coin collision stage.
- Watches each coin instance's Collision_Enable output. Each 1->0 fall is one pickup.
- Counts each coin at most once per level in a 2-digit BCD counter and pulses Life_Up on the 99->00 wrap.
- Drives a rising "coin pop" sprite at the collected coin's position for the renderer.

Parameters:
- NUM_COINS, 8: number of coin instances monitored (1..32).
- STEP_DIV, 20'd500000: clk cycles per 1-pixel pop rise step.
- POPUP_RISE, 16'd24: total pixels the pop sprite rises before disappearing.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- Coin_Enable  input  NUM_COINS  Collision_Enable from each coin instance; bit i = coin i.
- Coin_Coordinate  input  32*NUM_COINS  {x[15:0],y[15:0]} of coin i in bits [32i+31:32i].
- Level_Clear  input  1  synchronous clear of collected mask, pending mask and popup; counter kept.
- Coin_Count  output  8  BCD {tens,units}, 00..99.
- Life_Up  output  1  one-cycle pulse on the 99->00 wrap.
- Popup_Active  output  1  pop sprite visible.
- Popup_Coordinate  output  32  {x, y - rise_offset} of the pop sprite.
- Score  output  24  binary score (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async): all state and outputs go to 0. This covers prev_en, Collected, Pending, Coin_Count, Life_Up, Popup_Active, Popup_Coordinate, offset, divider and Score. State FSM goes to IDLE.
- Edge detect:
  - prev_en <= Coin_Enable every cycle.
  - fall[i] = prev_en[i] & ~Coin_Enable[i] & ~Collected[i].
  - A 0->1 rise is never an event, so coins coming out of reset do not count.
- Capture:
  - Pending <= (Pending & ~serviced) | fall.
  - Captured coordinate: Cap[i] <= Coin_Coordinate[i] in the cycle fall[i]=1. Needed because the coin outputs {-1,-1} after pickup.
  - A coin whose Collision_Enable returns to 1 and falls again is ignored: Collected[i] stays set until Level_Clear.
- Service: one pickup per cycle, lowest index of Pending first. For the serviced bit i, in that cycle:
  - clear Pending[i], set Collected[i];
  - units+1; at units 9, units becomes 0 and tens+1;
  - if count was 99, it becomes 00 and Life_Up=1 on the next cycle only;
  - start the popup from Cap[i].
- Latency: coin i falling at cycle N is counted by N+2 at the earliest. Any k simultaneous falls are all counted within k+1 cycles, none lost.
- Popup FSM, states IDLE and RISE:
  - IDLE->RISE on service: offset=0, divider=0, base=Cap[i].
  - In RISE, divider counts 0..STEP_DIV-1. At wrap, offset+1.
  - When offset reaches POPUP_RISE: RISE->IDLE and Popup_Active=0.
  - A service while in RISE restarts from the new base with offset=0.
  - Popup_Active=1 exactly in RISE.
  - Popup_Coordinate = {base.x, base.y - offset}. The subtraction is 16-bit wrap with no clamp. Output is 0 in IDLE.
- Level_Clear:
  - Highest priority after reset. Clears Collected, Pending and popup (to IDLE).
  - Coin_Count and Score are retained.
  - Falls in the same cycle are discarded. prev_en still updates.
- Registered outputs only. No combinational path from inputs to outputs.

Optional Feature:
- Macro COIN_TALLY_SCORE_EN.
- Defined:
  - Score += 200 per serviced coin, same cycle as the count update.
  - Saturates at 24'hFFFFFF.
  - Each Life_Up adds 1000 more, also saturating.
- Undefined: Score tied to 24'd0 and the adder logic is absent.

Test Plan:
- Reset then Coin_Enable 0->all-ones. Expected: Coin_Count=00, no Life_Up, Popup_Active=0.
- Coin 3 at {16'd100,16'd200} falls at cycle N, with STEP_DIV=2 and POPUP_RISE=4. Expected:
  - Coin_Count=01 by N+2.
  - Popup_Coordinate={100,200}, reaching {100,196} after 8 cycles.
  - Popup_Active drops after the next step.
- Coins 0, 5 and 7 fall in the same cycle. Expected: count 00->01->02->03 on consecutive cycles; final popup base is coin 7's captured coordinate.
- Coin 2 falls, rises back to 1, falls again. Expected: counted once. After Level_Clear, a further fall counts again.
- Preload to 98 via 98 distinct falls (NUM_COINS large, or Level_Clear between batches), then 2 more falls. Expected:
  - 99, then 00.
  - Life_Up high exactly one cycle.
  - With COIN_TALLY_SCORE_EN, Score=100*200+1000=21000.
- Assert rst_n low mid-popup with Pending nonzero. Expected: all outputs 0 immediately, without waiting for a clk edge; no pending count survives after release.
